if_of_skid_latch: RTL and testbench
===================================

// Module: if_of_skid_latch
// PURPOSE
//  Parametrised IF->OF pipeline register with a valid/ready handshake and a 2-entry skid buffer.
//  Sits between fetch and operand-fetch. Full throughput when the consumer is ready.
//  Holds one extra beat when the consumer stalls, so fetch sees backpressure one cycle late without losing data.
//  Synchronous flush discards wrong-path instructions and drives a NOP.
// PARAMETERS
//  PC_W       32            width of program counter field
//  INSTR_W    32            width of instruction field
//  NOP_INSTR  {INSTR_W{1'b0}}  value driven on instruction_out when not valid / after flush
// PORTS
//  clk              in   1        clock, all state updates on rising edge
//  rst              in   1        synchronous, active-high reset
//  flush            in   1        synchronous kill of all held/incoming beats
//  in_valid         in   1        fetch presents a beat
//  in_ready         out  1        latch can accept a beat (registered)
//  pc_in            in   PC_W     PC of incoming beat
//  instruction_in   in   INSTR_W  instruction of incoming beat
//  out_valid        out  1        pc_out/instruction_out hold a live beat
//  out_ready        in   1        OF stage consumes the beat
//  pc_out           out  PC_W     PC of head beat
//  instruction_out  out  INSTR_W  instruction of head beat (NOP_INSTR when !out_valid)
//  occupancy        out  2        beats held: 0, 1 or 2
// BEHAVIOUR
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Reset (rst=1 at edge): out_valid=0, in_ready=1, pc_out=0, instruction_out=NOP_INSTR, occupancy=0; skid cleared.
//  - Latency: a beat accepted at edge N appears on outputs after edge N (1 cycle) when the latch is empty.
//  - State = occupancy. Head register (H) drives the outputs; skid register (S) holds the second beat.
//  - EMPTY(0):
//      in_fire -> load H, go ONE.
//  - ONE(1):
//      in_fire & out_fire   -> H<=in, stay ONE.
//      in_fire & !out_fire  -> S<=in, go TWO.
//      !in_fire & out_fire  -> go EMPTY.
//      neither              -> hold.
//  - TWO(2): in_ready=0, so no in_fire is possible.
//      out_fire -> H<=S, go ONE.
//      otherwise hold.
//  - in_ready is registered: it is 1 in the cycle after the state is EMPTY or ONE, and 0 after TWO.
//    It never depends combinationally on out_ready.
//  - Beat order is strictly preserved. No beat is ever duplicated or dropped except by flush or reset.
//  - Flush (flush=1 at edge, rst=0):
//      next state EMPTY; out_valid=0; instruction_out=NOP_INSTR; in_ready=1.
//      pc_out holds its last value.
//      A beat presented in the flush cycle is discarded, even if in_fire.
//  - Priority: rst > flush > handshake.
//  - While out_valid=0, instruction_out=NOP_INSTR regardless of stale H contents.
//  - Inputs are sampled only on in_fire. Changes to pc_in/instruction_in while in_ready=0 have no effect.
//  - Outputs are stable while out_valid=1 & out_ready=0.
// TESTING
//  1. Reset: hold rst 3 cycles with in_valid=1, pc_in=4
//     -> out_valid=0, in_ready=1, instruction_out=NOP_INSTR, occupancy=0.
//  2. Streaming: out_ready=1; beats (4,0x12345678), (8,0x87654321) on consecutive cycles
//     -> each appears 1 cycle later, in order; occupancy stays 1.
//  3. Stall/skid: out_ready=0; send (4,A), (8,B), (12,C)
//     -> occupancy 2, in_ready=0 and C not accepted.
//     Then out_ready=1 -> outputs A, B, C in order with no loss.
//  4. Input churn during stall: with in_ready=0, change pc_in to 0xAABBCCDD each cycle
//     -> outputs and occupancy unchanged.
//  5. Flush with occupancy 2 and in_valid=1 (pc 16)
//     -> next cycle out_valid=0, instruction_out=NOP_INSTR, occupancy=0, in_ready=1; pc 16 never emerges.
//  6. rst and flush together mid-stream -> reset values (pc_out=0). Then rst=0 -> normal acceptance resumes.

Source files
------------

// File: rtl/if_of_skid_latch.sv
// IF->OF pipeline register with a valid/ready handshake and a two-entry skid buffer.
// The head register drives the outputs; the skid register absorbs one beat while OF stalls.
module if_of_skid_latch #(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instruction_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] instruction_out,
  output logic [1:0]         occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic [PC_W-1:0]    h_pc_q, h_pc_d;
  logic [INSTR_W-1:0] h_instr_q, h_instr_d;
  logic [PC_W-1:0]    s_pc_q, s_pc_d;
  logic [INSTR_W-1:0] s_instr_q, s_instr_d;
  logic               in_fire, out_fire;

  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    h_pc_d    = h_pc_q;
    h_instr_d = h_instr_q;
    s_pc_d    = s_pc_q;
    s_instr_d = s_instr_q;
    if (flush) begin
      // Head data is left untouched so pc_out keeps its last value.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            h_pc_d    = pc_in;
            h_instr_d = instruction_in;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            h_pc_d    = pc_in;
            h_instr_d = instruction_in;
          end else if (in_fire) begin
            s_pc_d    = pc_in;
            s_instr_d = instruction_in;
            state_d   = TWO;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            h_pc_d    = s_pc_q;
            h_instr_d = s_instr_q;
            state_d   = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // Registered backpressure: fetch learns of a full skid one cycle late, never from out_ready.
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      h_pc_q     <= '0;
      h_instr_q  <= NOP_INSTR;
      s_pc_q     <= '0;
      s_instr_q  <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      h_pc_q     <= h_pc_d;
      h_instr_q  <= h_instr_d;
      s_pc_q     <= s_pc_d;
      s_instr_q  <= s_instr_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign pc_out          = h_pc_q;
  assign instruction_out = out_valid ? h_instr_q : NOP_INSTR;
  assign occupancy       = state_q;

endmodule

// File: tb/tb_if_of_skid_latch.sv
// Scoreboard bench for if_of_skid_latch: accepted beats are queued, a monitor pops on every output fire.
module tb_if_of_skid_latch;

  localparam int PC_W = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = '0;

  logic               clk = 1'b0;
  logic               rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [PC_W-1:0]    pc_in, pc_out;
  logic [INSTR_W-1:0] instruction_in, instruction_out;
  logic [1:0]         occupancy;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ins;
  } beat_t;

  beat_t exp_q[$];
  int    tests = 0;
  int    fails = 0;

  if_of_skid_latch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .instruction_in(instruction_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .instruction_out(instruction_out),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a beat and hold it until the latch takes it; the beat is queued as expected output.
  task automatic send(input logic [PC_W-1:0] p, input logic [INSTR_W-1:0] i);
    int n = 0;
    pc_in = p;
    instruction_in = i;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: pc 0x%0h never accepted, in_ready=%0b required 1", p, in_ready);
    end else begin
      exp_q.push_back('{pc: p, ins: i});
    end
    tick();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: compares head beat with the scoreboard whenever OF consumes it.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: pc 0x%0h emerged, none expected", pc_out);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("out_pc", 64'(pc_out), 64'(e.pc));
          chk("out_instr", 64'(instruction_out), 64'(e.ins));
        end
      end
      if (!out_valid) chk("nop_when_idle", 64'(instruction_out), 64'(NOP));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset with a beat presented
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    pc_in = 32'd4; instruction_in = 32'h11;
    repeat (3) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_instr", 64'(instruction_out), 64'(NOP));
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_pc", 64'(pc_out), 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("idle_occ", 64'(occupancy), 64'd0);

    // 2. Streaming at full throughput
    out_ready = 1'b1;
    send(32'd4, 32'h12345678);
    chk("stream_lat_valid", 64'(out_valid), 64'd1);
    chk("stream_lat_pc", 64'(pc_out), 64'd4);
    send(32'd8, 32'h87654321);
    chk("stream_occ", 64'(occupancy), 64'd1);
    chk("stream_pc2", 64'(pc_out), 64'd8);
    in_valid = 1'b0;
    tick();
    chk("stream_empty", 64'(occupancy), 64'd0);
    chk("stream_qempty", 64'(exp_q.size()), 64'd0);

    // 3. Stall fills head and skid; third beat is held off
    out_ready = 1'b0;
    send(32'd4, 32'hA);
    send(32'd8, 32'hB);
    pc_in = 32'd12; instruction_in = 32'hC; in_valid = 1'b1;
    chk("stall_occ", 64'(occupancy), 64'd2);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("stall_occ_hold", 64'(occupancy), 64'd2);
    chk("stall_in_ready_hold", 64'(in_ready), 64'd0);

    // 4. Input churn while in_ready is low
    for (int k = 0; k < 3; k++) begin
      pc_in = 32'hAABBCCDD;
      instruction_in = $urandom;
      tick();
      chk("churn_pc", 64'(pc_out), 64'd4);
      chk("churn_instr", 64'(instruction_out), 64'hA);
      chk("churn_occ", 64'(occupancy), 64'd2);
    end
    out_ready = 1'b1;
    send(32'd12, 32'hC);
    in_valid = 1'b0;
    drain();

    // 5a. Flush with one beat held and an incoming beat that would fire
    out_ready = 1'b0;
    send(32'd28, 32'h28);
    in_valid = 1'b0;
    pc_in = 32'd16; instruction_in = 32'h16; in_valid = 1'b1; flush = 1'b1;
    chk("flush1_in_ready_pre", 64'(in_ready), 64'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    chk("flush1_valid", 64'(out_valid), 64'd0);
    chk("flush1_occ", 64'(occupancy), 64'd0);
    chk("flush1_pc_hold", 64'(pc_out), 64'd28);

    // 5b. Flush with occupancy 2
    send(32'd20, 32'h20);
    send(32'd24, 32'h24);
    pc_in = 32'd16; instruction_in = 32'h16; in_valid = 1'b1;
    chk("flush2_occ_pre", 64'(occupancy), 64'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    chk("flush2_valid", 64'(out_valid), 64'd0);
    chk("flush2_instr", 64'(instruction_out), 64'(NOP));
    chk("flush2_occ", 64'(occupancy), 64'd0);
    chk("flush2_in_ready", 64'(in_ready), 64'd1);
    chk("flush2_pc_hold", 64'(pc_out), 64'd20);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("flush2_no_emerge", 64'(out_valid), 64'd0);

    // 6. rst and flush together mid-stream
    out_ready = 1'b0;
    send(32'd32, 32'h32);
    pc_in = 32'd36; instruction_in = 32'h36; in_valid = 1'b1;
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    chk("rstfl_pc", 64'(pc_out), 64'd0);
    chk("rstfl_occ", 64'(occupancy), 64'd0);
    chk("rstfl_valid", 64'(out_valid), 64'd0);
    chk("rstfl_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    send(32'd44, 32'h44);
    in_valid = 1'b0;
    chk("resume_pc", 64'(pc_out), 64'd44);
    drain();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
